// File: rtl/operand_issue.sv
// Operand issue stage: scoreboard hazard detection, writeback bypass and a
// one-entry registered issue slot sitting between decode and execute.
module operand_issue #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dec_valid,
    output logic                  dec_ready,
    input  logic [ADDR_WIDTH-1:0] dec_rs1,
    input  logic [ADDR_WIDTH-1:0] dec_rs2,
    input  logic [ADDR_WIDTH-1:0] dec_rd,
    input  logic                  dec_uses_rs1,
    input  logic                  dec_uses_rs2,
    input  logic                  dec_writes_rd,
    output logic [ADDR_WIDTH-1:0] rf_rs1_addr,
    output logic [ADDR_WIDTH-1:0] rf_rs2_addr,
    input  logic [DATA_WIDTH-1:0] rf_rs1_data,
    input  logic [DATA_WIDTH-1:0] rf_rs2_data,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  iss_valid,
    input  logic                  iss_ready,
    output logic [DATA_WIDTH-1:0] iss_rs1_val,
    output logic [DATA_WIDTH-1:0] iss_rs2_val,
    output logic [ADDR_WIDTH-1:0] iss_rd,
    output logic                  iss_writes_rd,
    input  logic                  flush,
    output logic [31:0]           stall_cycles
);
    localparam int unsigned NUM_REGS  = 1 << ADDR_WIDTH;
    localparam int unsigned CNT_WIDTH = 32;

    typedef enum logic { EMPTY = 1'b0, FULL = 1'b1 } state_e;

    state_e                state_q;
    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   busy_d;
    logic [DATA_WIDTH-1:0] rs1_val_q;
    logic [DATA_WIDTH-1:0] rs1_val_d;
    logic [DATA_WIDTH-1:0] rs2_val_q;
    logic [DATA_WIDTH-1:0] rs2_val_d;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic                  wr_q;
    logic [CNT_WIDTH-1:0]  stall_q;
    logic [CNT_WIDTH-1:0]  stall_d;

    logic wb_live;
    logic wb_hit_rs1;
    logic wb_hit_rs2;
    logic wb_hit_rd;
    logic haz_rs1;
    logic haz_rs2;
    logic haz_rd;
    logic hazard;
    logic accept;
    logic flush_clr;

    assign rf_rs1_addr = dec_rs1;
    assign rf_rs2_addr = dec_rs2;

    // A writeback to a nonzero register both clears its busy bit and forwards its data.
    assign wb_live    = wb_en && (wb_rd != '0);
    assign wb_hit_rs1 = wb_live && (wb_rd == dec_rs1);
    assign wb_hit_rs2 = wb_live && (wb_rd == dec_rs2);
    assign wb_hit_rd  = wb_live && (wb_rd == dec_rd);

    assign haz_rs1 = dec_uses_rs1  && (dec_rs1 != '0) && busy_q[dec_rs1] && !wb_hit_rs1;
    assign haz_rs2 = dec_uses_rs2  && (dec_rs2 != '0) && busy_q[dec_rs2] && !wb_hit_rs2;
    assign haz_rd  = dec_writes_rd && (dec_rd  != '0) && busy_q[dec_rd]  && !wb_hit_rd;
    assign hazard  = dec_valid && (haz_rs1 || haz_rs2 || haz_rd);

    assign dec_ready = !hazard && !flush && ((state_q == EMPTY) || iss_ready);
    assign accept    = dec_valid && dec_ready;

    // Operand select: x0 reads zero, a same-cycle writeback wins over the register file.
    always_comb begin
        rs1_val_d = rf_rs1_data;
        rs2_val_d = rf_rs2_data;
        if (dec_rs1 == '0) begin
            rs1_val_d = '0;
        end else if (wb_hit_rs1) begin
            rs1_val_d = wb_data;
        end
        if (dec_rs2 == '0) begin
            rs2_val_d = '0;
        end else if (wb_hit_rs2) begin
            rs2_val_d = wb_data;
        end
    end

    // A squashed writer will never write back, so its pending bit is released here.
    assign flush_clr = flush && (state_q == FULL) && wr_q && (rd_q != '0);

    // Clears are applied before the accept-set so a new writer keeps its register busy.
    always_comb begin
        busy_d = busy_q;
        if (wb_live) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (flush_clr) begin
            busy_d[rd_q] = 1'b0;
        end
        if (accept && dec_writes_rd && (dec_rd != '0)) begin
            busy_d[dec_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        stall_d = stall_q;
        if (dec_valid && !dec_ready && (stall_q != '1)) begin
            stall_d = stall_q + CNT_WIDTH'(1);
        end
    end

    // Issue slot state machine with its payload registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            busy_q    <= '0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
            rd_q      <= '0;
            wr_q      <= 1'b0;
            stall_q   <= '0;
        end else begin
            busy_q  <= busy_d;
            stall_q <= stall_d;
            case (state_q)
                EMPTY: begin
                    if (!flush && accept) begin
                        state_q   <= FULL;
                        rs1_val_q <= rs1_val_d;
                        rs2_val_q <= rs2_val_d;
                        rd_q      <= dec_rd;
                        wr_q      <= dec_writes_rd;
                    end
                end
                FULL: begin
                    if (flush) begin
                        state_q <= EMPTY;
                    end else if (accept) begin
                        state_q   <= FULL;
                        rs1_val_q <= rs1_val_d;
                        rs2_val_q <= rs2_val_d;
                        rd_q      <= dec_rd;
                        wr_q      <= dec_writes_rd;
                    end else if (iss_ready) begin
                        state_q <= EMPTY;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign iss_valid     = (state_q == FULL);
    assign iss_rs1_val   = rs1_val_q;
    assign iss_rs2_val   = rs2_val_q;
    assign iss_rd        = rd_q;
    assign iss_writes_rd = wr_q;
    assign stall_cycles  = stall_q;

endmodule

// File: tb/tb_operand_issue.sv
// Bench for operand_issue: directed scenarios plus randomized traffic, all
// checked every cycle against a queue/set based reference model.
module tb_operand_issue;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          dec_valid;
    logic          dec_ready;
    logic [AW-1:0] dec_rs1;
    logic [AW-1:0] dec_rs2;
    logic [AW-1:0] dec_rd;
    logic          dec_uses_rs1;
    logic          dec_uses_rs2;
    logic          dec_writes_rd;
    logic [AW-1:0] rf_rs1_addr;
    logic [AW-1:0] rf_rs2_addr;
    logic [DW-1:0] rf_rs1_data;
    logic [DW-1:0] rf_rs2_data;
    logic          wb_en;
    logic [AW-1:0] wb_rd;
    logic [DW-1:0] wb_data;
    logic          iss_valid;
    logic          iss_ready;
    logic [DW-1:0] iss_rs1_val;
    logic [DW-1:0] iss_rs2_val;
    logic [AW-1:0] iss_rd;
    logic          iss_writes_rd;
    logic          flush;
    logic [31:0]   stall_cycles;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    bit          run_cmp  = 1'b0;

    operand_issue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2), .dec_writes_rd(dec_writes_rd),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_rs1_val(iss_rs1_val), .iss_rs2_val(iss_rs2_val),
        .iss_rd(iss_rd), .iss_writes_rd(iss_writes_rd),
        .flush(flush), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // Register file: combinational read, written by the writeback port.
    logic [DW-1:0] rf_mem [32];
    assign rf_rs1_data = rf_mem[rf_rs1_addr];
    assign rf_rs2_data = rf_mem[rf_rs2_addr];
    always @(posedge clk) begin
        if (wb_en && wb_rd != 0) rf_mem[wb_rd] <= wb_data;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending-writer set plus a queue holding the issue slot.
    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [AW-1:0] rd;
        logic          wr;
    } ent_t;

    ent_t        slot[$];
    bit          pending[int];
    int unsigned m_stall = 0;
    bit          m_zero  = 1'b1;

    function automatic bit still_busy(int r);
        return r != 0 && pending.exists(r) && !(wb_en && int'(wb_rd) == r);
    endfunction

    function automatic bit m_ready();
        bit hz;
        hz = dec_valid && ((dec_uses_rs1 && still_busy(int'(dec_rs1))) ||
                           (dec_uses_rs2 && still_busy(int'(dec_rs2))) ||
                           (dec_writes_rd && still_busy(int'(dec_rd))));
        return !hz && !flush && (slot.size() == 0 || iss_ready);
    endfunction

    function automatic logic [DW-1:0] m_operand(int r);
        if (r == 0) return '0;
        if (wb_en && int'(wb_rd) == r) return wb_data;
        return rf_mem[r];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            slot.delete();
            pending.delete();
            m_stall = 0;
            m_zero  = 1'b1;
        end else begin
            bit   rdy;
            ent_t e;
            rdy = m_ready();
            if (dec_valid && !rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
            if (wb_en && wb_rd != 0) pending.delete(int'(wb_rd));
            if (flush) begin
                if (slot.size() != 0 && slot[0].wr && slot[0].rd != 0) pending.delete(int'(slot[0].rd));
                slot.delete();
            end else begin
                if (slot.size() != 0 && iss_ready) void'(slot.pop_front());
                if (dec_valid && rdy) begin
                    e.a  = m_operand(int'(dec_rs1));
                    e.b  = m_operand(int'(dec_rs2));
                    e.rd = dec_rd;
                    e.wr = dec_writes_rd;
                    slot.push_back(e);
                    m_zero = 1'b0;
                    if (dec_writes_rd && dec_rd != 0) pending[int'(dec_rd)] = 1'b1;
                end
            end
        end
    end

    // Single compare process, mid-cycle.
    always @(negedge clk) begin
        if (run_cmp) begin
            chk("dec_ready", 64'(dec_ready), 64'(m_ready()));
            chk("rf_rs1_addr", 64'(rf_rs1_addr), 64'(dec_rs1));
            chk("rf_rs2_addr", 64'(rf_rs2_addr), 64'(dec_rs2));
            chk("slot_depth", 64'(slot.size() <= 1), 64'(1));
            chk("iss_valid", 64'(iss_valid), 64'(slot.size() != 0));
            if (slot.size() != 0) begin
                chk("iss_rs1_val", iss_rs1_val, slot[0].a);
                chk("iss_rs2_val", iss_rs2_val, slot[0].b);
                chk("iss_rd", 64'(iss_rd), 64'(slot[0].rd));
                chk("iss_writes_rd", 64'(iss_writes_rd), 64'(slot[0].wr));
            end else if (m_zero) begin
                chk("rst_payload", {iss_rs1_val ^ iss_rs2_val} | 64'(iss_rd) | 64'(iss_writes_rd)
                    | 64'(iss_rs1_val != 0), 64'(0));
            end
            chk("stall_cycles", 64'(stall_cycles), 64'(m_stall));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic v, input int rs1, input int rs2, input int rd,
                         input logic u1, input logic u2, input logic wr);
        dec_valid     = v;
        dec_rs1       = AW'(rs1);
        dec_rs2       = AW'(rs2);
        dec_rd        = AW'(rd);
        dec_uses_rs1  = u1;
        dec_uses_rs2  = u2;
        dec_writes_rd = wr;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = {$urandom, $urandom};
        rf_mem[0] = 64'hDEAD_BEEF_0000_0BAD;
        rf_mem[5] = 64'h11;
        rf_mem[7] = 64'h777;
        reset = 1'b1; flush = 1'b0; iss_ready = 1'b1;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        instr(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        run_cmp = 1'b1;
        chk("reset_iss_valid", 64'(iss_valid), 64'(0));
        chk("reset_iss_rs1", iss_rs1_val, 64'(0));
        chk("reset_iss_wr", 64'(iss_writes_rd), 64'(0));
        chk("reset_stall", 64'(stall_cycles), 64'(0));
        reset = 1'b0;

        // Plain read of x5.
        instr(1, 5, 0, 0, 1, 0, 0);
        #1 chk("t31_ready", 64'(dec_ready), 64'(1));
        tick();
        chk("t31_valid", 64'(iss_valid), 64'(1));
        chk("t31_rs1", iss_rs1_val, 64'h11);
        dec_valid = 1'b0;
        tick();

        // RAW on x3 resolved by a bypassed writeback.
        instr(1, 0, 0, 3, 0, 0, 1);
        tick();
        instr(1, 3, 0, 0, 1, 0, 0);
        #1 chk("t32_stall_ready", 64'(dec_ready), 64'(0));
        tick(); tick(); tick();
        chk("t32_stall_cnt", 64'(stall_cycles), 64'(3));
        wb_en = 1'b1; wb_rd = 5'd3; wb_data = 64'hAB;
        #1 chk("t32_wb_ready", 64'(dec_ready), 64'(1));
        tick();
        chk("t32_bypass", iss_rs1_val, 64'hAB);
        chk("t32_stall_hold", 64'(stall_cycles), 64'(3));
        wb_en = 1'b0; dec_valid = 1'b0;
        tick();

        // Back-pressure holds the slot, then back-to-back refill.
        iss_ready = 1'b0;
        instr(1, 5, 0, 0, 1, 0, 0);
        tick();
        instr(1, 0, 5, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            #1 chk("t33_bp_ready", 64'(dec_ready), 64'(0));
            chk("t33_bp_payload", iss_rs1_val, 64'h11);
            tick();
        end
        chk("t33_stall_cnt", 64'(stall_cycles), 64'(7));
        iss_ready = 1'b1;
        #1 chk("t33_refill_ready", 64'(dec_ready), 64'(1));
        tick();
        chk("t33_refill_rs2", iss_rs2_val, 64'h11);
        chk("t33_refill_rs1", iss_rs1_val, 64'h0);
        dec_valid = 1'b0;
        tick();
        chk("t33_drained", 64'(iss_valid), 64'(0));

        // Flush releases the squashed writer of x7.
        iss_ready = 1'b0;
        instr(1, 0, 0, 7, 0, 0, 1);
        tick();
        chk("t34_full_rd", 64'(iss_rd), 64'(7));
        dec_valid = 1'b0; flush = 1'b1;
        tick();
        chk("t34_flushed", 64'(iss_valid), 64'(0));
        flush = 1'b0; iss_ready = 1'b1;
        instr(1, 7, 0, 0, 1, 0, 0);
        #1 chk("t34_no_stall", 64'(dec_ready), 64'(1));
        tick();
        chk("t34_rs1", iss_rs1_val, 64'h777);
        dec_valid = 1'b0;
        tick();

        // x0 is never busy and always reads zero.
        instr(1, 0, 0, 0, 1, 0, 1);
        wb_en = 1'b1; wb_rd = '0; wb_data = 64'hFF;
        #1 chk("t35_ready", 64'(dec_ready), 64'(1));
        tick();
        chk("t35_rs1_zero", iss_rs1_val, 64'h0);
        chk("t35_wr", 64'(iss_writes_rd), 64'(1));
        wb_en = 1'b0;
        instr(1, 0, 0, 0, 1, 1, 0);
        #1 chk("t35_no_haz", 64'(dec_ready), 64'(1));
        tick();
        chk("t35_rs2_zero", iss_rs2_val, 64'h0);
        dec_valid = 1'b0;
        tick();

        // Reset while full with x9 pending.
        iss_ready = 1'b0;
        instr(1, 0, 0, 9, 0, 0, 1);
        tick();
        instr(1, 9, 0, 0, 1, 0, 0);
        #1 chk("t36_busy9", 64'(dec_ready), 64'(0));
        reset = 1'b1;
        tick();
        chk("t36_valid", 64'(iss_valid), 64'(0));
        chk("t36_rd", 64'(iss_rd), 64'(0));
        chk("t36_stall", 64'(stall_cycles), 64'(0));
        reset = 1'b0; iss_ready = 1'b1;
        #1 chk("t36_cleared", 64'(dec_ready), 64'(1));
        tick();
        chk("t36_accept", 64'(iss_valid), 64'(1));
        dec_valid = 1'b0;
        tick();

        // Randomized traffic over a small register window to provoke hazards.
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom % 200) == 0;
            flush     = ($urandom % 16) == 0;
            iss_ready = ($urandom % 3) != 0;
            instr(($urandom % 4) != 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), $urandom % 2 == 0, $urandom % 2 == 0, $urandom % 2 == 0);
            wb_en   = ($urandom % 3) == 0;
            wb_rd   = AW'($urandom_range(0, 7));
            wb_data = {$urandom, $urandom};
            tick();
        end

        run_cmp = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/operand_issue.md
OPERAND_ISSUE -- requirements
Module: operand_issue

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 5, register index width; DATA_WIDTH, default 64, register data width.
REQ-002 SHALL have clk  input  1  clock; all state updates on posedge clk.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have dec_valid  input  1, dec_ready  output  1  decode-to-issue handshake; transfer occurs when both are high.
REQ-005 SHALL have dec_rs1, dec_rs2, dec_rd  input  ADDR_WIDTH each  source and destination indices of the decoded instruction.
REQ-006 SHALL have dec_uses_rs1, dec_uses_rs2, dec_writes_rd  input  1 each  operand-use and destination-write flags.
REQ-007 SHALL have rf_rs1_addr, rf_rs2_addr  output  ADDR_WIDTH  register-file read addresses; rf_rs1_data, rf_rs2_data  input  DATA_WIDTH  combinational read data.
REQ-008 SHALL have wb_en  input  1, wb_rd  input  ADDR_WIDTH, wb_data  input  DATA_WIDTH  writeback snoop, identical to the register-file write port.
REQ-009 SHALL have iss_valid  output  1, iss_ready  input  1  issue-to-execute handshake.
REQ-010 SHALL have iss_rs1_val, iss_rs2_val  output  DATA_WIDTH, iss_rd  output  ADDR_WIDTH, iss_writes_rd  output  1  registered issue payload.
REQ-011 SHALL have flush  input  1  squashes the held issue slot (taken jump/branch).
REQ-012 SHALL have stall_cycles  output  32  decode-stall counter.

Function
REQ-013 SHALL drive rf_rs1_addr = dec_rs1 and rf_rs2_addr = dec_rs2 combinationally.
REQ-014 SHALL keep a 32-bit scoreboard busy[]; busy[0] SHALL always read 0.
REQ-015 SHALL define wb_hit(r) = wb_en && wb_rd == r && r != 0.
REQ-016 SHALL raise hazard when dec_valid and any of: dec_uses_rs1 && dec_rs1!=0 && busy[dec_rs1] && !wb_hit(dec_rs1); same for rs2; dec_writes_rd && dec_rd!=0 && busy[dec_rd] && !wb_hit(dec_rd) (WAW).
REQ-017 SHALL drive dec_ready = !hazard && !flush && (state==EMPTY || iss_ready), combinationally.
REQ-018 SHALL select each operand: index 0 -> 0; else wb_hit -> wb_data (bypass); else rf data.
REQ-019 SHALL, on accept (dec_valid && dec_ready), register operands, dec_rd and dec_writes_rd into the issue slot with one-cycle latency (iss_valid high the following cycle).
REQ-020 SHALL implement a two-state machine: EMPTY -> FULL on accept; FULL -> EMPTY on iss_ready without accept; FULL -> FULL on iss_ready with accept (payload replaced); FULL holds payload unchanged while !iss_ready.
REQ-021 SHALL set iss_valid = (state==FULL).
REQ-022 SHALL set busy[dec_rd] on accept when dec_writes_rd && dec_rd!=0.
REQ-023 SHALL clear busy[wb_rd] when wb_en && wb_rd!=0.
REQ-024 SHALL give set priority over clear when accept-set and writeback-clear target the same register in one cycle.
REQ-025 SHALL, on flush, go to EMPTY, accept nothing, and clear busy[iss_rd] if state==FULL && iss_writes_rd && iss_rd!=0; writeback clears still apply that cycle.
REQ-026 SHALL treat flush with iss_ready as a flush (payload is not considered issued).
REQ-027 SHALL increment stall_cycles each cycle with dec_valid && !dec_ready, saturating at 32'hFFFF_FFFF.
REQ-028 SHALL keep the payload stable while iss_valid && !iss_ready.

Reset
REQ-029 SHALL, on reset, clear busy[], set state EMPTY, iss_valid 0, iss_rs1_val/iss_rs2_val/iss_rd/iss_writes_rd 0, stall_cycles 0.
REQ-030 SHALL give reset priority over flush, accept and writeback; an instruction presented during reset is not accepted.

Verification
REQ-031 SHALL cover: rf data x5=0x11, accept rs1=5 with iss_ready=1 -> iss_valid next cycle, iss_rs1_val=0x11.
REQ-032 SHALL cover: accept rd=3 writer, then rs1=3 user -> dec_ready=0 and stall_cycles counts up until wb_en, wb_rd=3, wb_data=0xAB; in the wb cycle dec_ready=1 and iss_rs1_val=0xAB (bypass).
REQ-033 SHALL cover: iss_ready=0 for 4 cycles with slot FULL -> payload stable, dec_ready=0; iss_ready=1 -> slot drains or refills back-to-back.
REQ-034 SHALL cover: slot FULL with iss_rd=7 writer, flush -> iss_valid=0 next cycle, busy[7]=0, a following rs1=7 reader accepted without stall.
REQ-035 SHALL cover: rd=0 writer and rs1=0 user -> no busy set, no hazard, operand 0 regardless of rf data or wb_data.
REQ-036 SHALL cover: reset asserted while FULL with busy[9]=1 -> all outputs 0 and busy[] cleared next cycle.
